div_iter_clz: RTL and testbench

//  Multi-cycle MIPS DIV/DIVU unit in the EX stage. Consumes leading-zero counts of

---
 rtl/div_iter_clz_pkg.sv | 26 ++
 rtl/div_iter_clz_if.sv | 26 ++
 rtl/div_iter_clz_clz.sv | 20 ++
 rtl/div_iter_clz.sv | 176 +++++++++++++++++
 tb/tb_div_iter_clz.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/div_iter_clz_pkg.sv
// Shared definitions for the iterative CLZ-aligned divider: widths,
// FSM state encoding, divide-by-zero quotient and a magnitude helper.
package div_iter_clz_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    localparam logic [WIDTH-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        DIV_IDLE = 3'd0,
        DIV_PREP = 3'd1,
        DIV_ITER = 3'd2,
        DIV_FIX  = 3'd3,
        DIV_DONE = 3'd4
    } div_state_t;

    // Absolute value for signed operands; unsigned operands pass through.
    // The most negative value maps to itself, which is its correct
    // unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                   input logic             is_signed);
        return (is_signed && value[WIDTH-1]) ? -value : value;
    endfunction

endpackage

// File: rtl/div_iter_clz_if.sv
// Request/response bundle between the EX stage and the divider.
// The master is the pipeline side, the slave is the divider.
interface div_iter_clz_if;
    import div_iter_clz_pkg::*;

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             annul;
    logic             busy;
    logic             result_valid;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, is_signed, dividend, divisor, annul,
        input  busy, result_valid, quotient, remainder
    );

    modport slave (
        input  start, is_signed, dividend, divisor, annul,
        output busy, result_valid, quotient, remainder
    );

endinterface

// File: rtl/div_iter_clz_clz.sv
// Combinational count-leading-zeros. An all-zero input reports 0, so
// callers must detect a zero operand separately.
module div_iter_clz_clz
    import div_iter_clz_pkg::*;
(
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/div_iter_clz.sv
// Multi-cycle DIV/DIVU unit. Leading-zero counts of both magnitudes align
// the divisor under the dividend MSB so only the live quotient bits are
// iterated; trivial cases skip iteration entirely. Results land in
// separate output registers so they stay stable between operations.
module div_iter_clz
    import div_iter_clz_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    div_iter_clz_if.slave  bus
);

    div_state_t       state;
    div_state_t       next_state;

    logic [WIDTH-1:0] dividend_q;
    logic [WIDTH-1:0] divisor_q;
    logic             signed_q;
    logic             div_zero_q;

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] den_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic [WIDTH-1:0] ma;
    logic [WIDTH-1:0] mb;
    logic [CNT_W-1:0] za;
    logic [CNT_W-1:0] zb;
    logic [CNT_W-1:0] shift;
    logic             divisor_zero;
    logic             early_out;
    logic             accept;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_diff;
    logic             neg_quo;
    logic             neg_rem;

    assign ma           = magnitude(dividend_q, signed_q);
    assign mb           = magnitude(divisor_q, signed_q);
    assign divisor_zero = (mb == '0);
    // A divisor with more significant bits than the dividend gives q=0 at once.
    assign early_out    = (ma == '0) || (zb < za);
    assign shift        = zb - za;
    assign rem_ge       = (rem_q >= den_q);
    assign rem_diff     = rem_q - den_q;
    assign neg_quo      = signed_q && (dividend_q[WIDTH-1] ^ divisor_q[WIDTH-1]);
    assign neg_rem      = signed_q && dividend_q[WIDTH-1];
    assign accept       = (state == DIV_IDLE) && bus.start && !bus.annul;

    div_iter_clz_clz u_clz_a (
        .value (ma),
        .count (za)
    );

    div_iter_clz_clz u_clz_b (
        .value (mb),
        .count (zb)
    );

    assign bus.busy         = (state == DIV_PREP) || (state == DIV_ITER) || (state == DIV_FIX);
    assign bus.result_valid = (state == DIV_DONE) && !bus.annul;
    assign bus.quotient     = quotient_q;
    assign bus.remainder    = remainder_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Sequencing: annul abandons any op in flight and returns to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            DIV_IDLE: begin
                if (accept) begin
                    next_state = DIV_PREP;
                end
            end
            DIV_PREP: begin
                if (bus.annul) begin
                    next_state = DIV_IDLE;
                end else if (divisor_zero || early_out) begin
                    next_state = DIV_FIX;
                end else begin
                    next_state = DIV_ITER;
                end
            end
            DIV_ITER: begin
                if (bus.annul) begin
                    next_state = DIV_IDLE;
                end else if (cnt_q == '0) begin
                    next_state = DIV_FIX;
                end
            end
            DIV_FIX: begin
                next_state = bus.annul ? DIV_IDLE : DIV_DONE;
            end
            DIV_DONE: begin
                next_state = DIV_IDLE;
            end
            default: begin
                next_state = DIV_IDLE;
            end
        endcase
    end

    // Operand capture, alignment, restoring iteration and final sign fix.
    always_ff @(posedge clk) begin
        if (rst) begin
            dividend_q  <= '0;
            divisor_q   <= '0;
            signed_q    <= 1'b0;
            div_zero_q  <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            den_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (accept) begin
                        dividend_q <= bus.dividend;
                        divisor_q  <= bus.divisor;
                        signed_q   <= bus.is_signed;
                    end
                end
                DIV_PREP: begin
                    if (divisor_zero) begin
                        quo_q      <= DIV_BY_ZERO_Q;
                        rem_q      <= dividend_q;
                        div_zero_q <= 1'b1;
                    end else if (early_out) begin
                        quo_q      <= '0;
                        rem_q      <= ma;
                        div_zero_q <= 1'b0;
                    end else begin
                        quo_q      <= '0;
                        rem_q      <= ma;
                        den_q      <= mb << shift;
                        cnt_q      <= shift;
                        div_zero_q <= 1'b0;
                    end
                end
                DIV_ITER: begin
                    if (rem_ge) begin
                        rem_q <= rem_diff;
                    end
                    quo_q <= {quo_q[WIDTH-2:0], rem_ge};
                    den_q <= den_q >> 1;
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DIV_FIX: begin
                    if (!bus.annul) begin
                        quotient_q  <= (!div_zero_q && neg_quo) ? -quo_q : quo_q;
                        remainder_q <= (!div_zero_q && neg_rem) ? -rem_q : rem_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_clz.sv
// Bench for div_iter_clz: directed divides with literal expectations plus
// an arithmetic reference model checked against the outputs every cycle.
module tb_div_iter_clz;

    logic clk;
    logic rst;

    div_iter_clz_if bus();

    div_iter_clz dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks      = 0;
    int          errors      = 0;
    int          cycNow      = 0;
    bit          checking    = 0;
    bit          expActive   = 0;
    int          acceptCycle = 0;
    int          expLat      = 0;
    int          killRel     = 0;
    logic [31:0] expQ        = '0;
    logic [31:0] expR        = '0;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index used to measure latency from the accept cycle.
    always @(posedge clk) cycNow <= cycNow + 1;

    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int bitLen(input logic [31:0] x);
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            if (x[i]) n = i + 1;
        end
        return n;
    endfunction

    // Reference: plain arithmetic division plus latency from operand bit lengths.
    task automatic modelDivide(input logic sg, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] q, output logic [31:0] r, output int lat);
        logic [31:0] ma;
        logic [31:0] mb;
        int          la;
        int          lb;
        ma = (sg && a[31]) ? (32'd0 - a) : a;
        mb = (sg && b[31]) ? (32'd0 - b) : b;
        la = bitLen(ma);
        lb = bitLen(mb);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        if (mb == 32'd0 || ma == 32'd0 || lb > la) lat = 3;
        else lat = 4 + la - lb;
    endtask

    // Launch an op in the current (IDLE) cycle and arm the model.
    task automatic applyStimulus(input logic sg, input logic [31:0] a, input logic [31:0] b);
        bus.start     = 1'b1;
        bus.is_signed = sg;
        bus.dividend  = a;
        bus.divisor   = b;
        modelDivide(sg, a, b, expQ, expR, expLat);
        acceptCycle   = cycNow;
        killRel       = 1 << 20;
        expActive     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    // Wait (bounded) for result_valid and compare against literal values.
    task automatic checkOutput(input string name, input logic [31:0] q,
                               input logic [31:0] r, input int lat);
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (bus.result_valid === 1'b1) begin
                found = 1;
                checkValue({name, " quotient"}, bus.quotient, q);
                checkValue({name, " remainder"}, bus.remainder, r);
                checkValue({name, " latency"}, 32'(cycNow - acceptCycle), 32'(lat));
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: no result_valid, expected at cycle %0d", name, lat);
        end
        tick();
    endtask

    // Per-cycle comparison of busy/result_valid/results against the model.
    always @(negedge clk) begin
        if (checking) begin
            int rel;
            logic expBusy;
            logic expValid;
            rel      = cycNow - acceptCycle;
            expBusy  = expActive && rel >= 1 && rel < expLat && rel <= killRel;
            expValid = expActive && rel == expLat && rel < killRel;
            checkValue("model busy", 32'(bus.busy), 32'(expBusy));
            checkValue("model result_valid", 32'(bus.result_valid), 32'(expValid));
            if (expValid) begin
                checkValue("model quotient", bus.quotient, expQ);
                checkValue("model remainder", bus.remainder, expR);
            end
        end
    end

    // Runaway guard.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.annul     = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        checkValue("reset busy", 32'(bus.busy), 32'd0);
        checkValue("reset result_valid", 32'(bus.result_valid), 32'd0);
        checkValue("reset quotient", bus.quotient, 32'd0);
        checkValue("reset remainder", bus.remainder, 32'd0);
        checking = 1'b1;
        tick();

        $display("[TB] DIVU 100/7 with start pulse while busy");
        applyStimulus(1'b0, 32'd100, 32'd7);
        bus.start    = 1'b1;
        bus.dividend = 32'd1;
        bus.divisor  = 32'd1;
        tick();
        bus.start    = 1'b0;
        checkOutput("divu 100/7", 32'd14, 32'd2, 8);

        $display("[TB] signed divides");
        applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div -7/2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 5);
        applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE);
        checkOutput("div 7/-2", 32'hFFFF_FFFD, 32'd1, 5);
        applyStimulus(1'b1, 32'hFFFF_FFFB, 32'd9);
        checkOutput("div -5/9", 32'd0, 32'hFFFF_FFFB, 3);

        $display("[TB] early-out and divide by zero");
        applyStimulus(1'b0, 32'd5, 32'd9);
        checkOutput("divu 5/9", 32'd0, 32'd5, 3);
        applyStimulus(1'b0, 32'd0, 32'd3);
        checkOutput("divu 0/3", 32'd0, 32'd0, 3);
        applyStimulus(1'b0, 32'd1234, 32'd0);
        checkOutput("divu 1234/0", 32'hFFFF_FFFF, 32'd1234, 3);
        applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd0);
        checkOutput("div -100/0", 32'hFFFF_FFFF, 32'hFFFF_FF9C, 3);

        $display("[TB] longest latency and overflow wrap");
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1);
        checkOutput("divu max/1", 32'hFFFF_FFFF, 32'd0, 35);
        applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        checkOutput("div min/-1", 32'h8000_0000, 32'd0, 35);

        $display("[TB] start during DONE is ignored");
        applyStimulus(1'b0, 32'd100, 32'd7);
        repeat (7) tick();
        bus.start    = 1'b1;
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
        checkValue("done result_valid", 32'(bus.result_valid), 32'd1);
        checkValue("done quotient", bus.quotient, 32'd14);
        checkValue("done remainder", bus.remainder, 32'd2);
        tick();
        bus.start = 1'b0;
        checkValue("after done busy", 32'(bus.busy), 32'd0);
        tick();
        checkValue("after done busy 2", 32'(bus.busy), 32'd0);

        $display("[TB] annul with start in IDLE");
        bus.start    = 1'b1;
        bus.annul    = 1'b1;
        bus.dividend = 32'd50;
        bus.divisor  = 32'd5;
        tick();
        bus.start = 1'b0;
        bus.annul = 1'b0;
        checkValue("annul idle busy", 32'(bus.busy), 32'd0);
        tick();

        $display("[TB] annul mid-op then new op");
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1);
        repeat (4) tick();
        bus.annul = 1'b1;
        killRel   = 5;
        tick();
        bus.annul = 1'b0;
        checkValue("annul busy", 32'(bus.busy), 32'd0);
        checkValue("annul result_valid", 32'(bus.result_valid), 32'd0);
        applyStimulus(1'b0, 32'd100, 32'd7);
        checkOutput("after annul 100/7", 32'd14, 32'd2, 8);

        $display("[TB] reset mid-op then new op");
        applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1);
        repeat (4) tick();
        rst     = 1'b1;
        killRel = 5;
        tick();
        rst = 1'b0;
        checkValue("rst busy", 32'(bus.busy), 32'd0);
        checkValue("rst quotient", bus.quotient, 32'd0);
        checkValue("rst remainder", bus.remainder, 32'd0);
        applyStimulus(1'b0, 32'd100, 32'd7);
        checkOutput("after rst 100/7", 32'd14, 32'd2, 8);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
